// File: rtl/w5300_tx_stager.sv
`default_nettype none
// ============================================================================
//  Module      : w5300_tx_stager
//  Description : Double-buffered transmit frame stager in front of the
//                w5300_entry block. The application fills one bank while
//                the other is handed to w5300_entry, which reads it back
//                word by word.
//  Revision    : 1.0 - initial release
// ============================================================================
module w5300_tx_stager #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  tx_req,
    output logic [ADDR_WIDTH:0]   tx_len,
    input  logic [ADDR_WIDTH-1:0] tx_buffer_addr,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  busy_n,
    output logic                  frame_err
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    // Per-bank life cycle
    localparam logic [1:0] c_bank_empty   = 2'd0;
    localparam logic [1:0] c_bank_filling = 2'd1;
    localparam logic [1:0] c_bank_ready   = 2'd2;
    localparam logic [1:0] c_bank_sending = 2'd3;

    // Send handshake with w5300_entry
    localparam logic [1:0] c_send_idle = 2'd0;
    localparam logic [1:0] c_send_req  = 2'd1;
    localparam logic [1:0] c_send_xfer = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_cnt_max = '1;

    logic [DATA_WIDTH-1:0]      r_mem [0:1][0:c_depth-1];
    logic [1:0][1:0]            r_bank_st;
    logic [1:0][ADDR_WIDTH:0]   r_len;
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [ADDR_WIDTH-1:0]      r_wr_cnt;
    logic                       r_discard;
    logic                       r_frame_err;
    logic [1:0]                 r_send_st;
    logic [ADDR_WIDTH:0]        r_tx_len;
    logic [DATA_WIDTH-1:0]      r_rd_word;

    logic [1:0]                 w_send_nxt;
    logic                       w_send_start;
    logic                       w_send_done;
    logic                       w_fill_open;
    logic                       w_accept;
    logic                       w_store;
    logic                       w_close;
    logic                       w_close_full;

    // While discarding an overflowed frame's tail, words are swallowed
    // regardless of bank availability.
    assign w_fill_open  = (r_bank_st[r_wr_ptr] == c_bank_empty) ||
                          (r_bank_st[r_wr_ptr] == c_bank_filling);
    assign wr_ready     = r_discard | w_fill_open;
    assign w_accept     = wr_en & wr_ready;
    assign w_store      = w_accept & ~r_discard;
    assign w_close_full = w_store & ~wr_last & (r_wr_cnt == c_cnt_max);
    assign w_close      = (w_store & wr_last) | w_close_full;

    assign tx_req    = (r_send_st == c_send_req);
    assign tx_len    = r_tx_len;
    assign tx_data   = (r_send_st == c_send_idle) ? '0 : r_rd_word;
    assign frame_err = r_frame_err;

    // Send FSM next-state decode and bank hand-off strobes
    always_comb begin
        w_send_nxt   = r_send_st;
        w_send_start = 1'b0;
        w_send_done  = 1'b0;
        case (r_send_st)
            c_send_idle: begin
                if ((r_bank_st[r_rd_ptr] == c_bank_ready) && busy_n) begin
                    w_send_nxt   = c_send_req;
                    w_send_start = 1'b1;
                end
            end
            c_send_req: begin
                if (!busy_n) begin
                    w_send_nxt = c_send_xfer;
                end
            end
            c_send_xfer: begin
                if (busy_n) begin
                    w_send_nxt  = c_send_idle;
                    w_send_done = 1'b1;
                end
            end
            default: w_send_nxt = c_send_idle;
        endcase
    end

    // Send FSM state, read pointer and latched request length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_send_st <= c_send_idle;
            r_rd_ptr  <= 1'b0;
            r_tx_len  <= '0;
        end else begin
            r_send_st <= w_send_nxt;
            if (w_send_start) begin
                r_tx_len <= r_len[r_rd_ptr];
            end
            if (w_send_done) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Fill side and bank states; fill and send never target the same bank
    // in one cycle because they require disjoint bank states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st   <= {c_bank_empty, c_bank_empty};
            r_len       <= '0;
            r_wr_ptr    <= 1'b0;
            r_wr_cnt    <= '0;
            r_discard   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_store) begin
                r_bank_st[r_wr_ptr] <= w_close ? c_bank_ready : c_bank_filling;
                r_wr_cnt            <= w_close ? '0 : r_wr_cnt + ADDR_WIDTH'(1);
            end
            if (w_close) begin
                r_len[r_wr_ptr] <= {1'b0, r_wr_cnt} + (ADDR_WIDTH+1)'(1);
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_close_full) begin
                r_discard   <= 1'b1;
                r_frame_err <= 1'b1;
            end else if (w_accept && r_discard && wr_last) begin
                r_discard <= 1'b0;
            end
            if (w_send_start) begin
                r_bank_st[r_rd_ptr] <= c_bank_sending;
            end
            if (w_send_done) begin
                r_bank_st[r_rd_ptr] <= c_bank_empty;
            end
        end
    end

    // Bank storage: contents survive reset, only valid words are ever read
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr][r_wr_cnt] <= wr_data;
        end
    end

    // One-cycle read port; addresses past the frame length read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_word <= '0;
        end else if ({1'b0, tx_buffer_addr} < r_len[r_rd_ptr]) begin
            r_rd_word <= r_mem[r_rd_ptr][tx_buffer_addr];
        end else begin
            r_rd_word <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_w5300_tx_stager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w5300_tx_stager
//  Description : Self-checking bench for w5300_tx_stager. A frame-level
//                model (closed-frame sequence numbers, per-frame word
//                arrays, send phase) predicts every output each cycle;
//                directed scenarios pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_w5300_tx_stager;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = '0;
    logic          wr_last = 1'b0;
    logic          busy_n = 1'b1;
    logic [AW-1:0] tx_buffer_addr = '0;
    logic          wr_ready;
    logic          tx_req;
    logic [AW:0]   tx_len;
    logic [15:0]   tx_data;
    logic          frame_err;

    w5300_tx_stager #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .tx_req         (tx_req),
        .tx_len         (tx_len),
        .tx_buffer_addr (tx_buffer_addr),
        .tx_data        (tx_data),
        .busy_n         (busy_n),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    int          m_wr_seq;    // frames closed so far
    int          m_rd_seq;    // frames fully sent so far
    int          m_cnt;       // words in the frame being built
    int          m_phase;     // 0 idle, 1 requesting, 2 transferring
    int          m_txlen;
    bit          m_discard;
    bit          m_err;
    logic [15:0] m_rd_word;
    int          m_len [2];
    logic [15:0] m_fw  [2][DEPTH];

    int checks = 0;
    int errors = 0;
    bit busy_rand = 1'b0;
    bit addr_rand = 1'b0;
    int flen;

    task automatic model_reset();
        m_wr_seq  = 0;
        m_rd_seq  = 0;
        m_cnt     = 0;
        m_phase   = 0;
        m_txlen   = 0;
        m_discard = 1'b0;
        m_err     = 1'b0;
        m_rd_word = '0;
        m_len[0]  = 0;
        m_len[1]  = 0;
    endtask

    task automatic model_step();
        bit open;
        int rs;
        int ws;
        open = m_discard || ((m_wr_seq - m_rd_seq) < 2);
        rs   = m_rd_seq % 2;
        m_rd_word = (int'(tx_buffer_addr) < m_len[rs]) ? m_fw[rs][tx_buffer_addr] : 16'h0;
        case (m_phase)
            0: if ((m_wr_seq > m_rd_seq) && busy_n) begin
                   m_phase = 1;
                   m_txlen = m_len[rs];
               end
            1: if (!busy_n) m_phase = 2;
            default: if (busy_n) begin
                   m_phase = 0;
                   m_rd_seq++;
               end
        endcase
        if (wr_en && open) begin
            if (m_discard) begin
                if (wr_last) m_discard = 1'b0;
            end else begin
                ws = m_wr_seq % 2;
                m_fw[ws][m_cnt] = wr_data;
                if (wr_last) begin
                    m_len[ws] = m_cnt + 1;
                    m_cnt     = 0;
                    m_wr_seq++;
                end else if (m_cnt == DEPTH - 1) begin
                    m_len[ws] = DEPTH;
                    m_cnt     = 0;
                    m_wr_seq++;
                    m_err     = 1'b1;
                    m_discard = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // Model advances on each clock edge, or resets immediately with rst
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: compare all outputs with the model, then move random inputs
    task automatic tick();
        @(negedge clk);
        chk("wr_ready",  32'(wr_ready),  32'(m_discard || ((m_wr_seq - m_rd_seq) < 2)));
        chk("tx_req",    32'(tx_req),    32'(m_phase == 1));
        chk("tx_len",    32'(tx_len),    32'(m_txlen));
        chk("tx_data",   32'(tx_data),   (m_phase != 0) ? 32'(m_rd_word) : 32'h0);
        chk("frame_err", 32'(frame_err), 32'(m_err));
        if (busy_rand) busy_n = ($urandom_range(0, 9) < 7);
        if (addr_rand) tx_buffer_addr = AW'($urandom_range(0, 15));
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int  n;
        logic acc;
        n       = 0;
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        do begin
            acc = wr_ready;
            tick();
            n++;
        end while (!acc && n < 3000);
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: got wr_ready 0 expected 1 within 3000 cycles");
        end
    endtask

    task automatic finish_xfer();
        busy_n = 1'b0;
        tick();
        busy_n = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_wr_ready",  32'(wr_ready),  1);
        chk("rst_tx_req",    32'(tx_req),    0);
        chk("rst_tx_len",    32'(tx_len),    0);
        chk("rst_tx_data",   32'(tx_data),   0);
        chk("rst_frame_err", 32'(frame_err), 0);

        // Four-word frame: request one cycle after close, addressed read back
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b1);
        tick();
        chk("f4_tx_req", 32'(tx_req), 1);
        chk("f4_tx_len", 32'(tx_len), 4);
        tx_buffer_addr = AW'(2);
        tick();
        chk("f4_addr2", 32'(tx_data), 'h3333);
        tx_buffer_addr = AW'(4);
        tick();
        chk("f4_addr4_past_len", 32'(tx_data), 0);
        busy_n = 1'b0;
        tick();
        chk("f4_req_drop", 32'(tx_req), 0);
        busy_n = 1'b1;
        tick();
        chk("f4_idle_data", 32'(tx_data), 0);

        // Single-word frame
        send_word(16'hABCD, 1'b1);
        tick();
        chk("f1_tx_len", 32'(tx_len), 1);
        tx_buffer_addr = AW'(1);
        tick();
        chk("f1_addr1", 32'(tx_data), 0);
        tx_buffer_addr = AW'(0);
        tick();
        chk("f1_addr0", 32'(tx_data), 'hABCD);
        finish_xfer();

        // Back-to-back frames while the first is being transferred
        send_word(16'hA001, 1'b0);
        send_word(16'hA002, 1'b0);
        send_word(16'hA003, 1'b1);
        tick();
        chk("bb_first_req", 32'(tx_req), 1);
        chk("bb_first_len", 32'(tx_len), 3);
        busy_n = 1'b0;
        tick();
        send_word(16'hB001, 1'b0);
        send_word(16'hB002, 1'b0);
        send_word(16'hB003, 1'b1);
        chk("bb_full_ready", 32'(wr_ready), 0);
        wr_en   = 1'b1;
        wr_data = 16'hC001;
        tick();
        chk("bb_third_blocked", 32'(wr_ready), 0);
        wr_en   = 1'b0;
        tick();
        busy_n = 1'b1;
        tick();
        chk("bb_freed_ready", 32'(wr_ready), 1);
        chk("bb_freed_noreq", 32'(tx_req), 0);
        tick();
        chk("bb_second_req", 32'(tx_req), 1);
        chk("bb_second_len", 32'(tx_len), 3);
        tick();
        chk("bb_second_data", 32'(tx_data), 'hB001);
        finish_xfer();

        // Overflow: 4096 stored, forced close, tail discarded up to wr_last
        busy_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(16'(i) ^ 16'hA5A5, 1'b0);
        end
        send_word(16'hDEAD, 1'b0);
        send_word(16'hBEEF, 1'b1);
        chk("ov_frame_err", 32'(frame_err), 1);
        chk("ov_wr_ready",  32'(wr_ready),  1);
        busy_n = 1'b1;
        tick();
        chk("ov_tx_req", 32'(tx_req), 1);
        chk("ov_tx_len", 32'(tx_len), 4096);
        tx_buffer_addr = AW'(4095);
        tick();
        chk("ov_last_word", 32'(tx_data), 'hAA5A);
        tx_buffer_addr = AW'(0);
        tick();
        chk("ov_first_word", 32'(tx_data), 'hA5A5);
        finish_xfer();
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b1);
        tick();
        chk("post_ov_len", 32'(tx_len), 2);
        tick();
        chk("post_ov_word0", 32'(tx_data), 'h1234);
        tx_buffer_addr = AW'(2);
        tick();
        chk("post_ov_no_discard", 32'(tx_data), 0);
        finish_xfer();

        // Asynchronous reset while a request is outstanding
        send_word(16'h0101, 1'b0);
        send_word(16'h0202, 1'b1);
        tick();
        chk("ar_req_before", 32'(tx_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_tx_req",    32'(tx_req),    0);
        chk("ar_wr_ready",  32'(wr_ready),  1);
        chk("ar_frame_err", 32'(frame_err), 0);
        chk("ar_tx_len",    32'(tx_len),    0);
        chk("ar_tx_data",   32'(tx_data),   0);
        @(negedge clk);
        rst = 1'b0;
        tx_buffer_addr = AW'(0);
        send_word(16'h7777, 1'b1);
        tick();
        chk("ar_next_len", 32'(tx_len), 1);
        tick();
        chk("ar_next_data", 32'(tx_data), 'h7777);
        finish_xfer();

        // Randomized traffic against the model
        busy_rand = 1'b1;
        addr_rand = 1'b1;
        for (int f = 0; f < 80; f++) begin
            flen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                               : int'($urandom_range(1, 8));
            for (int w = 0; w < flen; w++) begin
                repeat ($urandom_range(0, 1)) tick();
                send_word(16'($urandom), (w == flen - 1));
            end
        end
        repeat (300) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
